// File: rtl/instr_encoder_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package     : instr_encoder_loader_pkg
// Description : Shared opcode encoding, field widths and imem word type for
//               the instruction encoder/loader.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_encoder_loader_pkg;

    localparam int INSTR_W  = 16;
    localparam int OPCODE_W = 4;
    localparam int REG_W    = 4;
    localparam int CTRL_W   = 2;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_ADDI = 4'b0100,
        OP_SUBI = 4'b0101,
        OP_ANDI = 4'b0110,
        OP_BR   = 4'b0111
    } opcode_e;

    typedef logic [INSTR_W-1:0] imem_word_t;

    // Word layout: {opcode, rd, rs1, rs2_imm}
    function automatic imem_word_t pack_instr(
        input opcode_e          op,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs1,
        input logic [REG_W-1:0] rs2_imm
    );
        return {op, rd, rs1, rs2_imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_loader_opcode_encoder.sv
`default_nettype none
// ============================================================================
// Module      : opcode_encoder
// Description : Combinational map from (ALUControl, ALUSrc, Branch) to a
//               4-bit opcode plus a legality flag.
// Revision    : 1.0 - initial release
// ============================================================================
module opcode_encoder
    import instr_encoder_loader_pkg::*;
(
    input  logic [CTRL_W-1:0] alu_ctrl,
    input  logic              alu_src,
    input  logic              branch,
    output opcode_e           opcode,
    output logic              legal
);

    always_comb begin
        opcode = opcode_e'({1'b0, alu_src | branch, alu_ctrl});
        legal  = 1'b0;
        case ({branch, alu_src})
            2'b00:   legal = 1'b1;
            2'b01:   legal = (alu_ctrl != 2'b11);
            // Branch shares the ctrl=11 slot of the I-type column
            2'b10:   legal = (alu_ctrl == 2'b11);
            default: legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader
// Description : Encodes a valid/ready stream of control tuples into 16-bit
//               instruction words and writes them sequentially into imem.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  in_alu_ctrl,
    input  logic               in_alu_src,
    input  logic               in_branch,
    input  logic [REG_W-1:0]   in_rd,
    input  logic [REG_W-1:0]   in_rs1,
    input  logic [REG_W-1:0]   in_rs2_imm,
    input  logic               in_last,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [ADDR_W:0]    count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [ADDR_W:0]   c_count_full = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_count_one  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_addr_last  = ADDR_W'(DEPTH-1);
    localparam logic [ADDR_W-1:0] c_addr_one   = ADDR_W'(1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_err;
    logic              r_last;
    imem_word_t        r_wdata;

    opcode_e           w_opcode;
    logic              w_legal;
    logic              w_full;
    logic              w_accept;
    logic [ADDR_W-1:0] w_addr_nxt;

    opcode_encoder u_opcode_encoder (
        .alu_ctrl (in_alu_ctrl),
        .alu_src  (in_alu_src),
        .branch   (in_branch),
        .opcode   (w_opcode),
        .legal    (w_legal)
    );

    assign w_full     = (r_count == c_count_full);
    assign w_accept   = in_valid && (r_state == ST_RUN);
    assign w_addr_nxt = (r_addr == c_addr_last) ? '0 : (r_addr + c_addr_one);

    // A full session stays open so a further tuple is reported as overflow
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        imem_we     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (w_full)       w_state_nxt = ST_DONE;
                    else if (w_legal) w_state_nxt = ST_WRITE;
                    else if (in_last) w_state_nxt = ST_DONE;
                end
            end
            ST_WRITE: begin
                imem_we     = 1'b1;
                busy        = 1'b1;
                w_state_nxt = r_last ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
            r_last  <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr  <= base_addr;
                        r_count <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_last <= in_last;
                        if (w_full || !w_legal) begin
                            r_err <= 1'b1;
                        end else begin
                            r_wdata <= pack_instr(w_opcode, in_rd, in_rs1, in_rs2_imm);
                        end
                    end
                end
                ST_WRITE: begin
                    r_addr  <= w_addr_nxt;
                    r_count <= r_count + c_count_one;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign err        = r_err;
    assign count      = r_count;

endmodule
`default_nettype wire
